// File: rtl/plus_asic_pkg.sv
// Shared constants and types for the Plus ASIC programmable raster interrupt.
// Holds the register offsets, line-counter width and the acknowledge-state encoding.
package plus_asic_pkg;

  localparam int          LINE_W   = 8;
  localparam logic [13:0] PRI_ADDR = 14'h2800;
  localparam logic [13:0] IVR_ADDR = 14'h2805;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_BUSY = 1'b1
  } ack_state_e;

  // IM2 vector: the low three bits are always zero on the bus
  function automatic logic [7:0] ivr_vector(input logic [7:0] ivr);
    return {ivr[7:3], 3'b000};
  endfunction

endpackage

// File: rtl/plus_sync_edge.sv
// cclk_en-gated edge detector: samples a CRTC strobe on each character clock
// and flags a change between the previous sample and the current input.
module plus_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic cclk_en,
  input  logic sig,
  output logic edge_det,
  output logic level_q
);

  logic sig_q;
  logic sig_d;

  // Hold the last sampled level between character-clock strobes
  always_comb begin
    sig_d = sig_q;
    if (cclk_en) begin
      sig_d = sig;
    end else begin
      sig_d = sig_q;
    end
  end

  // Sample register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  // level_q is the old value, so a falling edge is edge_det & level_q
  assign edge_det = cclk_en & (sig_q ^ sig);
  assign level_q  = sig_q;

endmodule

// File: rtl/plus_pri_irq.sv
// Plus-mode programmable raster interrupt: counts scan lines from CRTC syncs,
// raises pri_irq on the programmed line and answers the IM2 acknowledge.
module plus_pri_irq
  import plus_asic_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cclk_en,
  input  logic              plus_mode,
  input  logic              crtc_hs,
  input  logic              crtc_vs,
  input  logic              asic_wr,
  input  logic [13:0]       asic_addr,
  input  logic [7:0]        asic_din,
  input  logic              m1_n,
  input  logic              iorq_n,
  output logic              pri_irq,
  output logic [7:0]        int_vector,
  output logic              vector_oe,
  output logic              ga_int_inhibit,
  output logic [LINE_W-1:0] line_cnt
);

  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0] pri_q, pri_d;
  logic [7:0]        ivr_q, ivr_d;
  logic              pending_q, pending_d;
  logic              pri_irq_q, pri_irq_d;
  logic              iorq_n_q, iorq_n_d;
  ack_state_e        state_q, state_d;

  logic              hs_edge, hs_old, vs_edge, vs_old;
  logic              hs_fall, vs_rise;
  logic [LINE_W-1:0] line_inc;
  logic              wr_pri, wr_ivr;
  logic              set_hit, iorq_rise, ack_req, ack_done;

  plus_sync_edge u_hs_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .cclk_en  (cclk_en),
    .sig      (crtc_hs),
    .edge_det (hs_edge),
    .level_q  (hs_old)
  );

  plus_sync_edge u_vs_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .cclk_en  (cclk_en),
    .sig      (crtc_vs),
    .edge_det (vs_edge),
    .level_q  (vs_old)
  );

  assign hs_fall   = hs_edge & hs_old;
  assign vs_rise   = vs_edge & ~vs_old;
  assign line_inc  = line_cnt_q + LINE_W'(1);
  assign wr_pri    = asic_wr && (asic_addr == PRI_ADDR);
  assign wr_ivr    = asic_wr && (asic_addr == IVR_ADDR);
  // Compare against the post-increment count; a same-cycle VS clear suppresses it
  assign set_hit   = hs_fall && !vs_rise && (pri_q != '0) && (line_inc == pri_q);
  assign iorq_rise = iorq_n && !iorq_n_q;
  assign ack_req   = !m1_n && !iorq_n && pending_q;
  assign ack_done  = (state_q == ACK_BUSY) && iorq_rise;

  // Next-state for registers, line counter, pending flag and acknowledge FSM
  always_comb begin
    pri_d      = pri_q;
    ivr_d      = ivr_q;
    line_cnt_d = line_cnt_q;
    pending_d  = pending_q;
    state_d    = state_q;
    iorq_n_d   = iorq_n;

    if (wr_pri) begin
      pri_d = asic_din[LINE_W-1:0];
    end else begin
      pri_d = pri_q;
    end

    if (wr_ivr) begin
      ivr_d = {asic_din[7:1], 1'b0};
    end else begin
      ivr_d = ivr_q;
    end

    if (vs_rise) begin
      line_cnt_d = '0;
    end else if (hs_fall) begin
      line_cnt_d = line_inc;
    end else begin
      line_cnt_d = line_cnt_q;
    end

    // A new hit outranks the acknowledge clear; a PRI write cancels everything
    if (!plus_mode) begin
      pending_d = 1'b0;
    end else if (wr_pri) begin
      pending_d = 1'b0;
    end else if (set_hit) begin
      pending_d = 1'b1;
    end else if (ack_done) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (!plus_mode) begin
      state_d = ACK_IDLE;
    end else begin
      case (state_q)
        ACK_IDLE: begin
          if (ack_req) begin
            state_d = ACK_BUSY;
          end else begin
            state_d = ACK_IDLE;
          end
        end
        ACK_BUSY: begin
          if (iorq_rise) begin
            state_d = ACK_IDLE;
          end else begin
            state_d = ACK_BUSY;
          end
        end
        default: state_d = ACK_IDLE;
      endcase
    end

    pri_irq_d = pending_d & plus_mode;
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt_q <= '0;
      pri_q      <= '0;
      ivr_q      <= 8'h00;
      pending_q  <= 1'b0;
      pri_irq_q  <= 1'b0;
      iorq_n_q   <= 1'b0;
      state_q    <= ACK_IDLE;
    end else begin
      line_cnt_q <= line_cnt_d;
      pri_q      <= pri_d;
      ivr_q      <= ivr_d;
      pending_q  <= pending_d;
      pri_irq_q  <= pri_irq_d;
      iorq_n_q   <= iorq_n_d;
      state_q    <= state_d;
    end
  end

  assign pri_irq        = pri_irq_q;
  assign vector_oe      = (state_q == ACK_BUSY);
  assign int_vector     = vector_oe ? ivr_vector(ivr_q) : 8'h00;
  assign ga_int_inhibit = plus_mode & (pri_q != '0);
  assign line_cnt       = line_cnt_q;

endmodule

// File: tb/tb_plus_pri_irq.sv
// Self-checking bench for plus_pri_irq: register table, directed raster/ack
// sequences and a randomized run against a behavioural line/interrupt model.
module tb_plus_pri_irq;

  localparam logic [13:0] A_PRI = 14'h2800;
  localparam logic [13:0] A_IVR = 14'h2805;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cclk_en = 1'b0;
  logic        plus_mode = 1'b0;
  logic        crtc_hs = 1'b0;
  logic        crtc_vs = 1'b0;
  logic        asic_wr = 1'b0;
  logic [13:0] asic_addr = 14'h0000;
  logic [7:0]  asic_din = 8'h00;
  logic        m1_n = 1'b1;
  logic        iorq_n = 1'b1;
  logic        pri_irq;
  logic [7:0]  int_vector;
  logic        vector_oe;
  logic        ga_int_inhibit;
  logic [7:0]  line_cnt;

  plus_pri_irq dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cclk_en        (cclk_en),
    .plus_mode      (plus_mode),
    .crtc_hs        (crtc_hs),
    .crtc_vs        (crtc_vs),
    .asic_wr        (asic_wr),
    .asic_addr      (asic_addr),
    .asic_din       (asic_din),
    .m1_n           (m1_n),
    .iorq_n         (iorq_n),
    .pri_irq        (pri_irq),
    .int_vector     (int_vector),
    .vector_oe      (vector_oe),
    .ga_int_inhibit (ga_int_inhibit),
    .line_cnt       (line_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: line number, programmed line, vector and request state
  int m_line, m_pri, m_ivr;
  bit m_pending, m_ack, m_irq, m_hs, m_vs, m_iorq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_line = 0; m_pri = 0; m_ivr = 0;
    m_pending = 0; m_ack = 0; m_irq = 0; m_hs = 0; m_vs = 0; m_iorq = 0;
  endtask

  task automatic m_clock();
    bit hs_fall, vs_rise, hit, iorq_rise, wr_pri, wr_ivr, new_pend, new_ack;
    int nxt;
    if (!reset_n) begin
      m_reset();
    end else begin
      hs_fall   = cclk_en && m_hs && !crtc_hs;
      vs_rise   = cclk_en && !m_vs && crtc_vs;
      nxt       = (m_line + 1) % 256;
      hit       = hs_fall && !vs_rise && (m_pri != 0) && (nxt == m_pri);
      iorq_rise = iorq_n && !m_iorq;
      wr_pri    = asic_wr && (asic_addr == A_PRI);
      wr_ivr    = asic_wr && (asic_addr == A_IVR);
      if (!plus_mode)                new_pend = 0;
      else if (wr_pri)               new_pend = 0;
      else if (hit)                  new_pend = 1;
      else if (m_ack && iorq_rise)   new_pend = 0;
      else                           new_pend = m_pending;
      if (!plus_mode)  new_ack = 0;
      else if (m_ack)  new_ack = !iorq_rise;
      else             new_ack = !m1_n && !iorq_n && m_pending;
      if (vs_rise)      m_line = 0;
      else if (hs_fall) m_line = nxt;
      if (cclk_en) begin m_hs = crtc_hs; m_vs = crtc_vs; end
      m_iorq = iorq_n;
      if (wr_pri) m_pri = int'(asic_din);
      if (wr_ivr) m_ivr = int'(asic_din) & 32'hFE;
      m_pending = new_pend;
      m_ack     = new_ack;
      m_irq     = new_pend && plus_mode;
    end
  endtask

  function automatic logic [18:0] m_expect();
    logic [7:0] ivr8, line8, vec;
    ivr8  = 8'(m_ivr);
    line8 = 8'(m_line);
    vec   = m_ack ? (ivr8 & 8'hF8) : 8'h00;
    return {m_irq, m_ack, vec, (plus_mode && (m_pri != 0)), line8};
  endfunction

  task automatic step();
    @(posedge clk);
    m_clock();
    #1;
    chk("cycle", {13'd0, pri_irq, vector_oe, int_vector, ga_int_inhibit, line_cnt},
        {13'd0, m_expect()});
  endtask

  task automatic tick(input bit en);
    cclk_en = en;
    step();
    cclk_en = 1'b0;
  endtask

  task automatic hs_pulse();
    crtc_hs = 1'b1; tick(1'b1); tick(1'b0);
    crtc_hs = 1'b0; tick(1'b1); tick(1'b0);
  endtask

  task automatic vs_pulse();
    crtc_vs = 1'b1; tick(1'b1); tick(1'b0);
    crtc_vs = 1'b0; tick(1'b1); tick(1'b0);
  endtask

  task automatic wr(input logic [13:0] addr, input logic [7:0] din);
    asic_wr = 1'b1; asic_addr = addr; asic_din = din;
    step();
    asic_wr = 1'b0;
  endtask

  typedef struct {
    bit          plus;
    logic [13:0] addr;
    logic [7:0]  din;
    bit          exp_ga;
  } vec_t;

  vec_t tbl[8];
  bit   seen;

  initial begin
    m_reset();
    tbl[0] = '{1'b1, A_PRI,    8'h00, 1'b0};
    tbl[1] = '{1'b1, A_PRI,    8'h01, 1'b1};
    tbl[2] = '{1'b1, 14'h2801, 8'h00, 1'b1};
    tbl[3] = '{1'b1, A_IVR,    8'h00, 1'b1};
    tbl[4] = '{1'b1, 14'h0800, 8'h00, 1'b1};
    tbl[5] = '{1'b0, 14'h2804, 8'h00, 1'b0};
    tbl[6] = '{1'b1, A_PRI,    8'h00, 1'b0};
    tbl[7] = '{1'b1, A_PRI,    8'h80, 1'b1};

    // Reset state
    step(); step();
    reset_n = 1'b1;
    step();
    chk("reset_outputs", {13'd0, pri_irq, vector_oe, int_vector, ga_int_inhibit, line_cnt}, 32'd0);

    // Register decode table
    for (int i = 0; i < 8; i++) begin
      plus_mode = tbl[i].plus;
      wr(tbl[i].addr, tbl[i].din);
      chk($sformatf("tbl_ga_%0d", i), {31'd0, ga_int_inhibit}, {31'd0, tbl[i].exp_ga});
    end

    // 1. Basic raster hit on line 40
    plus_mode = 1'b1;
    wr(A_PRI, 8'd40);
    vs_pulse();
    for (int i = 0; i < 39; i++) hs_pulse();
    chk("line_39", {24'd0, line_cnt}, 32'd39);
    chk("irq_not_early", {31'd0, pri_irq}, 32'd0);
    crtc_hs = 1'b1; tick(1'b1); tick(1'b0);
    crtc_hs = 1'b0;
    chk("irq_before_fall", {31'd0, pri_irq}, 32'd0);
    tick(1'b1);
    chk("irq_after_40", {31'd0, pri_irq}, 32'd1);
    chk("line_40", {24'd0, line_cnt}, 32'd40);
    tick(1'b0);

    // 2. Acknowledge with vector E8
    wr(A_IVR, 8'hE8);
    m1_n = 1'b0; iorq_n = 1'b0;
    step();
    chk("ack_oe", {31'd0, vector_oe}, 32'd1);
    chk("ack_vector", {24'd0, int_vector}, 32'hE8);
    step();
    m1_n = 1'b1; iorq_n = 1'b1;
    step();
    chk("ack_done_irq", {31'd0, pri_irq}, 32'd0);
    chk("ack_done_oe", {31'd0, vector_oe}, 32'd0);

    // 3. PRI disabled
    wr(A_PRI, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      hs_pulse();
      seen = seen | pri_irq;
    end
    chk("pri0_no_irq", {31'd0, seen}, 32'd0);
    chk("pri0_ga", {31'd0, ga_int_inhibit}, 32'd0);
    wr(A_PRI, 8'd1);
    chk("pri1_ga", {31'd0, ga_int_inhibit}, 32'd1);

    // 4. Wrap and same-cycle VS/HS
    wr(A_PRI, 8'd4);
    vs_pulse();
    for (int i = 0; i < 3; i++) hs_pulse();
    chk("wrap_irq_3", {31'd0, pri_irq}, 32'd0);
    hs_pulse();
    chk("wrap_irq_4", {31'd0, pri_irq}, 32'd1);
    wr(A_PRI, 8'd4);
    chk("wrap_write_clear", {31'd0, pri_irq}, 32'd0);
    for (int i = 0; i < 256; i++) hs_pulse();
    chk("wrap_line_260", {24'd0, line_cnt}, 32'd4);
    chk("wrap_irq_260", {31'd0, pri_irq}, 32'd1);
    wr(A_PRI, 8'd5);
    crtc_hs = 1'b1; tick(1'b1); tick(1'b0);
    crtc_hs = 1'b0; crtc_vs = 1'b1;
    tick(1'b1);
    chk("vs_hs_line", {24'd0, line_cnt}, 32'd0);
    chk("vs_hs_no_hit", {31'd0, pri_irq}, 32'd0);
    tick(1'b0);
    crtc_vs = 1'b0; tick(1'b1); tick(1'b0);

    // 5. Set versus acknowledge race
    for (int i = 0; i < 5; i++) hs_pulse();
    chk("race_first_hit", {31'd0, pri_irq}, 32'd1);
    m1_n = 1'b0; iorq_n = 1'b0;
    step();
    chk("race_ack_oe", {31'd0, vector_oe}, 32'd1);
    vs_pulse();
    for (int i = 0; i < 4; i++) hs_pulse();
    crtc_hs = 1'b1; tick(1'b1); tick(1'b0);
    crtc_hs = 1'b0; iorq_n = 1'b1; m1_n = 1'b1;
    tick(1'b1);
    chk("race_pending", {31'd0, pri_irq}, 32'd1);
    chk("race_oe_off", {31'd0, vector_oe}, 32'd0);
    tick(1'b0);
    wr(A_PRI, 8'd5);
    chk("race_write_cancel", {31'd0, pri_irq}, 32'd0);

    // 6. Reset during acknowledge
    vs_pulse();
    for (int i = 0; i < 5; i++) hs_pulse();
    m1_n = 1'b0; iorq_n = 1'b0;
    step();
    chk("rst_pre_oe", {31'd0, vector_oe}, 32'd1);
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("rst_mid_ack", {13'd0, pri_irq, vector_oe, int_vector, ga_int_inhibit, line_cnt}, 32'd0);
    m1_n = 1'b1; iorq_n = 1'b1;
    step(); step();
    reset_n = 1'b1;
    step();
    wr(A_PRI, 8'd3);
    for (int i = 0; i < 2; i++) hs_pulse();
    chk("post_rst_no_irq", {31'd0, pri_irq}, 32'd0);
    hs_pulse();
    chk("post_rst_irq", {31'd0, pri_irq}, 32'd1);
    chk("post_rst_line", {24'd0, line_cnt}, 32'd3);

    // Randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      cclk_en = ($urandom_range(2) == 0);
      if ($urandom_range(3) == 0) crtc_hs = ~crtc_hs;
      if ($urandom_range(47) == 0) crtc_vs = ~crtc_vs;
      if ($urandom_range(199) == 0) plus_mode = ~plus_mode;
      asic_wr = ($urandom_range(39) == 0);
      case ($urandom_range(2))
        0:       asic_addr = A_PRI;
        1:       asic_addr = A_IVR;
        default: asic_addr = 14'($urandom);
      endcase
      asic_din = (asic_addr == A_PRI) ? 8'($urandom_range(6)) : 8'($urandom);
      if ($urandom_range(5) == 0) iorq_n = ~iorq_n;
      m1_n = 1'($urandom_range(1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
